// File: rtl/or_nor_trig_array.sv
// Multi-channel masked OR/NOR trigger front end: synchronised inputs, rising-edge
// detection, stretched pulse with holdoff, optional retrigger and saturating counters.
module or_nor_trig_array #(
   parameter int NCH         = 4,
   parameter int NIN         = 4,
   parameter int CW          = 8,
   parameter int CNTW        = 16,
   parameter int SYNC_STAGES = 2,
   parameter int RETRIG      = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH*NIN-1:0]   d,
   input  logic [NCH*NIN-1:0]   mask,
   input  logic [CW-1:0]        stretch,
   input  logic [CW-1:0]        holdoff,
   input  logic                 cnt_clr,
   output logic [NCH-1:0]       q,
   output logic [NCH-1:0]       q_n,
   output logic [NCH-1:0]       busy,
   output logic [NCH*CNTW-1:0]  count
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STRETCH = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   localparam int              NB      = NCH * NIN;
   localparam logic [CW-1:0]   CW_ONE  = CW'(1);
   localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0][NB-1:0] sync_q;
   logic [NB-1:0]                  sync_s;
   logic [NB-1:0]                  in_act;
   logic [NCH-1:0]                 or_cur;
   logic [NCH-1:0]                 or_prev_q;
   logic [NCH-1:0]                 trig;
   logic [CW-1:0]                  stretch_eff;

   // Stage 0 captures the raw input; the highest index is the settled copy.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q    <= '0;
         or_prev_q <= '0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], d};
         or_prev_q <= or_cur;
      end
   end

   assign sync_s      = sync_q[SYNC_STAGES-1];
   assign in_act      = sync_s & mask;
   assign stretch_eff = (stretch == '0) ? CW_ONE : stretch;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      state_t          state_q, state_d;
      logic [CW-1:0]   cnt_s_q, cnt_s_d;
      logic [CW-1:0]   cnt_h_q, cnt_h_d;
      logic [CW-1:0]   hold_r_q, hold_r_d;
      logic            q_q, q_d;
      logic            q_n_q;
      logic            accept;
      logic [CNTW-1:0] cnt_q, cnt_d;

      assign or_cur[gi] = |in_act[gi*NIN +: NIN];
      assign trig[gi]   = or_cur[gi] & ~or_prev_q[gi];

      always_comb begin
         state_d  = state_q;
         cnt_s_d  = cnt_s_q;
         cnt_h_d  = cnt_h_q;
         hold_r_d = hold_r_q;
         q_d      = q_q;
         accept   = 1'b0;
         case (state_q)
            ST_IDLE: begin
               q_d = 1'b0;
               if (trig[gi]) begin
                  state_d  = ST_STRETCH;
                  cnt_s_d  = stretch_eff;
                  hold_r_d = holdoff;
                  q_d      = 1'b1;
                  accept   = 1'b1;
               end
            end
            ST_STRETCH: begin
               q_d = 1'b1;
               if ((RETRIG != 0) && trig[gi]) begin
                  cnt_s_d = stretch_eff;
                  accept  = 1'b1;
               end else if (cnt_s_q == CW_ONE) begin
                  q_d = 1'b0;
                  if (hold_r_q == '0) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_HOLDOFF;
                     cnt_h_d = hold_r_q;
                  end
               end else begin
                  cnt_s_d = cnt_s_q - CW_ONE;
               end
            end
            ST_HOLDOFF: begin
               q_d = 1'b0;
               if (cnt_h_q == CW_ONE) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_h_d = cnt_h_q - CW_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               q_d     = 1'b0;
            end
         endcase
      end

      // Clear beats a coincident increment; the counter sticks at all-ones.
      always_comb begin
         cnt_d = cnt_q;
         if (cnt_clr) begin
            cnt_d = '0;
         end else if (accept && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            state_q  <= ST_IDLE;
            cnt_s_q  <= '0;
            cnt_h_q  <= '0;
            hold_r_q <= '0;
            q_q      <= 1'b0;
            q_n_q    <= 1'b1;
            cnt_q    <= '0;
         end else begin
            state_q  <= state_d;
            cnt_s_q  <= cnt_s_d;
            cnt_h_q  <= cnt_h_d;
            hold_r_q <= hold_r_d;
            q_q      <= q_d;
            q_n_q    <= ~q_d;
            cnt_q    <= cnt_d;
         end
      end

      assign q[gi]                    = q_q;
      assign q_n[gi]                  = q_n_q;
      assign busy[gi]                 = (state_q != ST_IDLE);
      assign count[gi*CNTW +: CNTW]   = cnt_q;
   end

endmodule

// File: tb/tb_or_nor_trig_array.sv
// Scoreboard bench: three DUT variants (default, retrigger, 4-bit counters) share stimulus;
// a monitor measures every q pulse and matches it against queued expectations.
module tb_or_nor_trig_array;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] d, mask;
   logic [7:0]  stretch, holdoff;
   logic        cnt_clr;

   logic [3:0]  q0, qn0, b0, q1, qn1, b1, q2, qn2, b2;
   logic [63:0] cnt0, cnt1;
   logic [15:0] cnt2;

   int checks   = 0;
   int failures = 0;
   bit mon_en   = 1'b0;

   typedef struct {
      int ch;
      int w;
   } pulse_t;

   pulse_t exp0[$];
   pulse_t exp1[$];
   pulse_t exp2[$];
   int     wcnt [3][4];
   logic [3:0] qv [3];
   logic [3:0] qnv [3];

   assign qv[0]  = q0;
   assign qv[1]  = q1;
   assign qv[2]  = q2;
   assign qnv[0] = qn0;
   assign qnv[1] = qn1;
   assign qnv[2] = qn2;

   always #5 clk = ~clk;

   or_nor_trig_array #(.NCH(4), .NIN(4), .CW(8), .CNTW(16), .SYNC_STAGES(2), .RETRIG(0)) dut0 (
      .clk(clk), .reset(reset), .d(d), .mask(mask), .stretch(stretch), .holdoff(holdoff),
      .cnt_clr(cnt_clr), .q(q0), .q_n(qn0), .busy(b0), .count(cnt0));

   or_nor_trig_array #(.NCH(4), .NIN(4), .CW(8), .CNTW(16), .SYNC_STAGES(2), .RETRIG(1)) dut1 (
      .clk(clk), .reset(reset), .d(d), .mask(mask), .stretch(stretch), .holdoff(holdoff),
      .cnt_clr(cnt_clr), .q(q1), .q_n(qn1), .busy(b1), .count(cnt1));

   or_nor_trig_array #(.NCH(4), .NIN(4), .CW(8), .CNTW(4), .SYNC_STAGES(2), .RETRIG(0)) dut2 (
      .clk(clk), .reset(reset), .d(d), .mask(mask), .stretch(stretch), .holdoff(holdoff),
      .cnt_clr(cnt_clr), .q(q2), .q_n(qn2), .busy(b2), .count(cnt2));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic push_k(input int k, input int ch, input int w);
      pulse_t p;
      p.ch = ch;
      p.w  = w;
      case (k)
         0:       exp0.push_back(p);
         1:       exp1.push_back(p);
         default: exp2.push_back(p);
      endcase
   endtask

   task automatic push_all(input int ch, input int w);
      for (int k = 0; k < 3; k++) push_k(k, ch, w);
   endtask

   task automatic pop_check(input int k, input int ch, input int w);
      pulse_t e;
      bit     got = 1'b0;
      case (k)
         0:       if (exp0.size() > 0) begin e = exp0.pop_front(); got = 1'b1; end
         1:       if (exp1.size() > 0) begin e = exp1.pop_front(); got = 1'b1; end
         default: if (exp2.size() > 0) begin e = exp2.pop_front(); got = 1'b1; end
      endcase
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL pulse dut%0d: got ch%0d width %0d, expected no pulse", k, ch, w);
      end else if (e.ch != ch || e.w != w) begin
         failures++;
         $display("FAIL pulse dut%0d: got ch%0d width %0d, expected ch%0d width %0d",
                  k, ch, w, e.ch, e.w);
      end else begin
         $display("ok   pulse dut%0d ch%0d width %0d", k, ch, w);
      end
   endtask

   // Pulse monitor: a pulse is reported on the cycle q is seen low again.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (qnv[k] !== ~qv[k]) begin
               failures++;
               $display("FAIL q_n dut%0d: got %b, expected %b", k, qnv[k], ~qv[k]);
            end
            for (int c = 0; c < 4; c++) begin
               if (qv[k][c]) begin
                  wcnt[k][c]++;
               end else if (wcnt[k][c] != 0) begin
                  pop_check(k, c, wcnt[k][c]);
                  wcnt[k][c] = 0;
               end
            end
         end
      end
   end

   task automatic apply(input logic [15:0] v);
      d = v;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " dut0 q"}, 64'(q0), 64'h0);
      chk({tag, " dut0 q_n"}, 64'(qn0), 64'hF);
      chk({tag, " dut0 busy"}, 64'(b0), 64'h0);
      chk({tag, " dut0 count"}, cnt0, 64'h0);
      chk({tag, " dut1 q"}, 64'(q1), 64'h0);
      chk({tag, " dut1 busy"}, 64'(b1), 64'h0);
      chk({tag, " dut1 count"}, cnt1, 64'h0);
      chk({tag, " dut2 q_n"}, 64'(qn2), 64'hF);
      chk({tag, " dut2 busy"}, 64'(b2), 64'h0);
      chk({tag, " dut2 count"}, 64'(cnt2), 64'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [15:0] noise [6];
      int          pat;
      noise = '{16'hFFFF, 16'h0000, 16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hFFFF};

      reset = 1'b1; d = '0; mask = '0; stretch = 8'd3; holdoff = 8'd0; cnt_clr = 1'b0;
      repeat (4) apply('0);
      @(negedge clk);
      chk_idle("reset");
      reset = 1'b0;
      mon_en = 1'b1;

      // All inputs masked: input activity must not reach the channels.
      for (int i = 0; i < 6; i++) apply(noise[i]);
      repeat (4) apply('0);
      @(negedge clk);
      chk_idle("masked");
      mask = 16'hFFFF;

      // Single-cycle input on ch1, stretch 3.
      push_all(1, 3);
      apply(16'h0020);
      apply(16'h0000);
      @(negedge clk);
      chk("t2 q before edge2", 64'(q0), 64'h0);
      apply(16'h0000);
      @(negedge clk);
      chk("t2 q after edge2", 64'(q0), 64'h2);
      chk("t2 q_n after edge2", 64'(qn0), 64'hD);
      chk("t2 busy after edge2", 64'(b0), 64'h2);
      repeat (8) apply('0);
      chk("t2 dut0 count", cnt0, 64'h0000_0000_0001_0000);
      chk("t2 dut2 count", 64'(cnt2), 64'h0010);

      // Held level gives one pulse; holdoff then rejects an edge and accepts the next one.
      stretch = 8'd2; holdoff = 8'd4;
      push_all(0, 2);
      repeat (20) apply(16'h0001);
      repeat (12) apply('0);
      chk("t3 level count ch0", 64'(cnt0[15:0]), 64'd1);
      push_all(0, 2);
      push_all(0, 2);
      pat = 8'b1001_0001;
      for (int e = 0; e < 8; e++) apply(pat[e] ? 16'h0001 : 16'h0000);
      repeat (14) apply('0);
      chk("t3 holdoff count ch0", 64'(cnt0[15:0]), 64'd3);

      // Three edges 3 cycles apart on ch2: retrigger extends, non-retrigger splits.
      stretch = 8'd4; holdoff = 8'd0;
      push_k(0, 2, 4); push_k(0, 2, 4);
      push_k(1, 2, 10);
      push_k(2, 2, 4); push_k(2, 2, 4);
      pat = 7'b100_1001;
      for (int e = 0; e < 7; e++) apply(pat[e] ? 16'h0100 : 16'h0000);
      repeat (10) apply('0);
      chk("t4 dut0 count ch2", 64'(cnt0[47:32]), 64'd2);
      chk("t4 dut1 count ch2", 64'(cnt1[47:32]), 64'd3);
      chk("t4 dut2 count ch2", 64'(cnt2[11:8]), 64'd2);

      // Unmasking an input that is already high is a rising edge, seen at the next clock.
      stretch = 8'd2;
      mask = 16'hFFF0;
      repeat (5) apply(16'h0002);
      @(negedge clk);
      chk("mask held-high no trig", 64'(b0[0]), 64'h0);
      push_all(0, 2);
      mask = 16'hFFFF;
      @(negedge clk);
      chk("unmask trig q0", 64'(q0[0]), 64'h1);
      repeat (4) apply(16'h0002);
      repeat (4) apply('0);
      chk("unmask count ch0", 64'(cnt0[15:0]), 64'd4);

      // Coincident triggers on every channel.
      for (int c = 0; c < 4; c++) push_all(c, 2);
      apply(16'h8421);
      repeat (8) apply('0);
      chk("simul dut0 count", cnt0, 64'h0001_0003_0002_0005);
      chk("simul dut1 count", cnt1, 64'h0001_0004_0002_0005);
      chk("simul dut2 count", 64'(cnt2), 64'h1325);

      // stretch=0 acts as 1; sixteen more triggers saturate the 4-bit counter.
      stretch = 8'd0;
      for (int i = 0; i < 16; i++) begin
         push_all(3, 1);
         apply(16'h1000);
         repeat (3) apply('0);
      end
      repeat (4) apply('0);
      chk("sat dut0 count", cnt0, 64'h0011_0003_0002_0005);
      chk("sat dut1 count", cnt1, 64'h0011_0004_0002_0005);
      chk("sat dut2 count", 64'(cnt2), 64'hF325);

      // Clear on the same edge that accepts a trigger.
      push_all(3, 1);
      apply(16'h1000);
      apply('0);
      cnt_clr = 1'b1;
      apply('0);
      cnt_clr = 1'b0;
      repeat (4) apply('0);
      chk("clr dut0 count", cnt0, 64'h0);
      chk("clr dut1 count", cnt1, 64'h0);
      chk("clr dut2 count", 64'(cnt2), 64'h0);

      // Reset two cycles into a 5-cycle pulse truncates it.
      stretch = 8'd5;
      push_all(1, 2);
      apply(16'h0010);
      repeat (3) apply('0);
      @(negedge clk);
      chk("pre-reset busy", 64'(b0), 64'h2);
      chk("pre-reset count", cnt0, 64'h0000_0000_0001_0000);
      reset = 1'b1;
      apply('0);
      @(negedge clk);
      chk_idle("mid reset");
      reset = 1'b0;
      repeat (10) apply('0);
      @(negedge clk);
      chk_idle("post reset");

      repeat (3) apply('0);
      chk("dut0 pulses outstanding", 64'(exp0.size()), 64'h0);
      chk("dut1 pulses outstanding", 64'(exp1.size()), 64'h0);
      chk("dut2 pulses outstanding", 64'(exp2.size()), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
